// File: rtl/aes_dec_session_ctrl.sv
// Shares one AES-128 decrypt core between two requesters: round-robin grant,
// then latch, hold core in reset, start, wait fixed latency, return plaintext.
module aes_dec_session_ctrl #(
    parameter int DATA_W    = 128,
    parameter int KEY_SETUP = 2,
    parameter int CORE_LAT  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [DATA_W-1:0] ct0,
    input  logic [DATA_W-1:0] key0,
    output logic              ack0,
    output logic              vld0,
    output logic [DATA_W-1:0] pt0,
    input  logic              req1,
    input  logic [DATA_W-1:0] ct1,
    input  logic [DATA_W-1:0] key1,
    output logic              ack1,
    output logic              vld1,
    output logic [DATA_W-1:0] pt1,
    output logic              core_reset_n,
    output logic              core_reset_n_ka,
    output logic              core_en,
    output logic              core_start,
    output logic [DATA_W-1:0] core_ct,
    output logic [DATA_W-1:0] core_key,
    input  logic [DATA_W-1:0] core_pt,
    output logic              busy,
    output logic              gnt_id
);

    // state | meaning
    // IDLE  | core held in reset, arbitrating requests
    // LATCH | winner's ct/key captured, ack pulsed
    // SETUP | core and key expansion held in reset for KEY_SETUP cycles
    // START | resets released, start pulsed
    // WAIT  | core running for CORE_LAT cycles
    // DONE  | plaintext captured, vld pulsed to the winner
    typedef enum logic [2:0] {IDLE, LATCH, SETUP, START, WAIT, DONE} state_t;

    localparam logic [4:0] KEY_SETUP_CNT = 5'(KEY_SETUP);
    localparam logic [4:0] CORE_LAT_CNT  = 5'(CORE_LAT);

    state_t     state;
    logic [4:0] cnt;
    logic       win;

    // On a tie the requester not served last time wins.
    always_comb begin
        win = req1;
        if (req0 && req1) win = ~gnt_id;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            ack0            <= 1'b0;
            ack1            <= 1'b0;
            vld0            <= 1'b0;
            vld1            <= 1'b0;
            pt0             <= '0;
            pt1             <= '0;
            core_reset_n    <= 1'b0;
            core_reset_n_ka <= 1'b0;
            core_en         <= 1'b0;
            core_start      <= 1'b0;
            core_ct         <= '0;
            core_key        <= '0;
            busy            <= 1'b0;
            gnt_id          <= 1'b1;
        end else begin
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            vld0       <= 1'b0;
            vld1       <= 1'b0;
            core_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    core_reset_n    <= 1'b0;
                    core_reset_n_ka <= 1'b0;
                    core_en         <= 1'b0;
                    if (req0 || req1) begin
                        state  <= LATCH;
                        busy   <= 1'b1;
                        gnt_id <= win;
                        if (win) begin
                            ack1     <= 1'b1;
                            core_ct  <= ct1;
                            core_key <= key1;
                        end else begin
                            ack0     <= 1'b1;
                            core_ct  <= ct0;
                            core_key <= key0;
                        end
                    end
                end
                LATCH: begin
                    state <= SETUP;
                    cnt   <= KEY_SETUP_CNT;
                end
                SETUP: begin
                    if (cnt <= 5'd1) begin
                        state           <= START;
                        core_reset_n    <= 1'b1;
                        core_reset_n_ka <= 1'b1;
                        core_en         <= 1'b1;
                        core_start      <= 1'b1;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                START: begin
                    state <= WAIT;
                    cnt   <= CORE_LAT_CNT;
                end
                WAIT: begin
                    if (cnt <= 5'd1) begin
                        state   <= DONE;
                        core_en <= 1'b0;
                        if (gnt_id) begin
                            pt1  <= core_pt;
                            vld1 <= 1'b1;
                        end else begin
                            pt0  <= core_pt;
                            vld0 <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                DONE: begin
                    state           <= IDLE;
                    busy            <= 1'b0;
                    core_reset_n    <= 1'b0;
                    core_reset_n_ka <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_dec_session_ctrl.md
Name: aes_dec_session_ctrl

Overview:
- Sequencer and arbiter that shares one AES-128 `decrypt` core between two requesters, for example the scan-decrypt paths of two stacked dies.
- Runs one decrypt session at a time:
  - latches ciphertext and key,
  - resets the core and its key-expansion unit,
  - pulses the core's `start`,
  - waits a fixed latency,
  - captures the plaintext and returns it to the winning requester.
- Arbitration between the two requesters is round-robin.

Parameters:
- DATA_W, 128, width of ciphertext, key and plaintext.
- KEY_SETUP, 2, cycles that `core_reset_n` and `core_reset_n_ka` are held low before start (1..15).
- CORE_LAT, 12, cycles from the `core_start` cycle to valid `core_pt` (1..31).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 session request; level, held until ack0.
- ct0  in  DATA_W  requester 0 ciphertext; stable while req0=1.
- key0  in  DATA_W  requester 0 initial key; stable while req0=1.
- ack0  out  1  one-cycle pulse: request 0 accepted, inputs latched.
- vld0  out  1  one-cycle pulse: pt0 updated.
- pt0  out  DATA_W  requester 0 plaintext; held until the next vld0.
- req1, ct1, key1, ack1, vld1, pt1: identical set for requester 1.
- core_reset_n  out  1  to core `reset_n`.
- core_reset_n_ka  out  1  to core `reset_n_ka`.
- core_en  out  1  to core `en`.
- core_start  out  1  to core `start`.
- core_ct  out  DATA_W  to core `cyphertext`.
- core_key  out  DATA_W  to core `initial_key`.
- core_pt  in  DATA_W  from core `plaintext`.
- busy  out  1  high in every state except IDLE.
- gnt_id  out  1  requester currently or most recently served.

Behaviour:
- All outputs are registered.
- Reset values:
  - ack*, vld*, core_start, core_en, busy: 0.
  - core_reset_n and core_reset_n_ka: 0, so the core is held in reset.
  - pt0, pt1, core_ct, core_key: 0.
  - gnt_id: 1, so requester 0 wins the first tie.
  - FSM: IDLE.
- FSM states: IDLE, LATCH, SETUP, START, WAIT, DONE.
- IDLE:
  - core_reset_n and core_reset_n_ka are 0.
  - If exactly one req is high, grant it.
  - If both are high, grant `~gnt_id` (round-robin).
  - On a grant, go to LATCH.
- LATCH (1 cycle):
  - core_ct and core_key are loaded from the winner's ct/key.
  - gnt_id is updated.
  - The winner's ack is high for this cycle only.
  - Next state is SETUP.
- SETUP (KEY_SETUP cycles, counted by `cnt`):
  - Both core resets stay low.
  - Next state is START.
- START (1 cycle):
  - core_reset_n=1, core_reset_n_ka=1, core_en=1, core_start=1.
  - Next state is WAIT.
- WAIT (CORE_LAT cycles):
  - Resets high, core_en=1, core_start=0.
  - When the count expires, go to DONE.
- DONE (1 cycle):
  - pt[gnt_id] <= core_pt, and vld[gnt_id]=1 in the same cycle.
  - core_en=0.
  - Next state is IDLE.
- Latency:
  - If req is first seen in IDLE at edge k, ack is high at edge k+1.
  - vld is high at edge k+3+KEY_SETUP+CORE_LAT, which is k+17 with default parameters.
  - Next-session throughput: one IDLE cycle between DONE and the next LATCH.
- The request is consumed at ack.
  - A req still high after ack starts a new session only if it is still high when the FSM next evaluates IDLE.
  - Requesters must drop req the cycle after ack to avoid a repeat session.
- A req that rises or falls during a session is ignored until IDLE. Changes to ct/key after ack have no effect.
- The non-granted requester waits at most one session, because of round-robin.
- Counters are 5 bits, reload on state entry and count down to 1. No wrap is possible within the legal parameter ranges.
- Reset asserted mid-session:
  - The FSM returns to IDLE next edge and the core is forced into reset.
  - No vld is issued for the aborted session.
  - pt registers are cleared.

Test Plan:
- Single request: req0=1 with ct0 = FIPS-197 C.1 ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a and key0 = 000102…0f. Required response: ack0 at k+1, vld0 at k+17, pt0 = 00112233445566778899aabbccddeeff, vld1/ack1 stay 0.
- Simultaneous requests after reset: req0=req1=1 in the same cycle. Required response: requester 0 served first; ack1 in the LATCH that follows the first DONE plus one IDLE cycle; gnt_id toggles 0 then 1; each pt holds its own result.
- Round-robin fairness: req0 held continuously while req1 pulses each time IDLE is reached. Required response: grants alternate 0,1,0,1; no requester is starved.
- Input isolation: change ct0/key0 to 0 one cycle after ack0. Required response: pt0 still equals the FIPS plaintext; core_ct is unchanged throughout the session.
- Mid-session reset: assert reset for one cycle during WAIT. Required response: next edge busy=0, core_reset_n=0, no vld; a fresh request afterwards completes normally at +16 cycles after ack.
- Parameter sweep: KEY_SETUP=1, CORE_LAT=12. Required response: vld exactly 16 cycles after the req edge; core_start is high for exactly one cycle per session.
